// File: rtl/pim_arbiter.sv
// pim_arbiter: two-port (core / SPI) round-robin arbiter in front of a
// single-ported PIM array. One access is in flight at a time; the FSM walks
// IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE for every granted transaction.
module pim_arbiter #(
    parameter int XLEN       = 32,
    parameter int RD_LATENCY = 2    // legal range 1..7
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            c_req_i,
    input  logic            c_we_i,
    input  logic [XLEN-1:0] c_addr_i,
    input  logic [XLEN-1:0] c_wdata_i,
    output logic            c_gnt_o,
    output logic            c_rvalid_o,
    output logic [XLEN-1:0] c_rdata_o,

    input  logic            s_req_i,
    input  logic            s_we_i,
    input  logic [XLEN-1:0] s_addr_i,
    input  logic [XLEN-1:0] s_wdata_i,
    output logic            s_gnt_o,
    output logic            s_rvalid_o,
    output logic [XLEN-1:0] s_rdata_o,

    output logic            pim_en_o,
    output logic            pim_we_o,
    output logic [XLEN-1:0] pim_addr_o,
    output logic [XLEN-1:0] pim_wr_o,
    input  logic [XLEN-1:0] pim_rd_i,

    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT spans RD_LATENCY cycles: the counter loads RD_LATENCY-1 and the
    // terminal-count cycle itself is the last WAIT cycle, so pim_rd_i is
    // sampled exactly RD_LATENCY cycles after the ISSUE cycle.
    localparam logic [2:0] WAIT_LOAD = 3'(RD_LATENCY - 1);

    state_t     state;
    logic       ptr;        // 0: core has priority, 1: SPI has priority
    logic       port_q;     // port of the transaction in flight (1 = SPI)
    logic       we_q;
    logic [2:0] wait_cnt;

    logic       pick_spi;
    logic       in_idle;

    // Winner selection: a lone requester always wins, otherwise the pointer decides.
    always_comb begin
        pick_spi = s_req_i && (!c_req_i || ptr);
        in_idle  = (state == IDLE) && !rst_i;
    end

    assign c_gnt_o    = in_idle && c_req_i && !pick_spi;
    assign s_gnt_o    = in_idle && pick_spi;
    assign busy_o     = (state != IDLE) && !rst_i;
    assign pim_en_o   = (state == ISSUE) && !rst_i;
    assign pim_we_o   = (state == ISSUE) && we_q && !rst_i;
    assign c_rvalid_o = (state == RESP) && !port_q && !rst_i;
    assign s_rvalid_o = (state == RESP) && port_q && !rst_i;

    // Transaction FSM: capture at grant, issue, wait out read latency, respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            wait_cnt   <= 3'd0;
            pim_addr_o <= '0;
            pim_wr_o   <= '0;
            c_rdata_o  <= '0;
            s_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req_i || s_req_i) begin
                        port_q     <= pick_spi;
                        we_q       <= pick_spi ? s_we_i    : c_we_i;
                        pim_addr_o <= pick_spi ? s_addr_i  : c_addr_i;
                        pim_wr_o   <= pick_spi ? s_wdata_i : c_wdata_i;
                        ptr        <= ~pick_spi;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (port_q) begin
                            s_rdata_o <= pim_rd_i;
                        end else begin
                            c_rdata_o <= pim_rd_i;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pim_arbiter.sv
// tb_pim_arbiter: three arbiter builds (RD_LATENCY 1, 2, 7) driven by
// independent random requesters and checked every cycle against a
// transaction-level timing model.
module tb_pim_arbiter;

    localparam int NI   = 3;
    localparam int NCYC = 3000;
    localparam int PH_A = 200;   // both ports request writes continuously

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [NI];
    logic        c_req    [NI];
    logic        c_we     [NI];
    logic [31:0] c_addr   [NI];
    logic [31:0] c_wdata  [NI];
    logic        c_gnt    [NI];
    logic        c_rvalid [NI];
    logic [31:0] c_rdata  [NI];
    logic        s_req    [NI];
    logic        s_we     [NI];
    logic [31:0] s_addr   [NI];
    logic [31:0] s_wdata  [NI];
    logic        s_gnt    [NI];
    logic        s_rvalid [NI];
    logic [31:0] s_rdata  [NI];
    logic        pim_en   [NI];
    logic        pim_we   [NI];
    logic [31:0] pim_addr [NI];
    logic [31:0] pim_wr   [NI];
    logic [31:0] pim_rd   [NI];
    logic        busy     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pim_arbiter #(
            .XLEN       (32),
            .RD_LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 7))
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .c_req_i    (c_req[g]),
            .c_we_i     (c_we[g]),
            .c_addr_i   (c_addr[g]),
            .c_wdata_i  (c_wdata[g]),
            .c_gnt_o    (c_gnt[g]),
            .c_rvalid_o (c_rvalid[g]),
            .c_rdata_o  (c_rdata[g]),
            .s_req_i    (s_req[g]),
            .s_we_i     (s_we[g]),
            .s_addr_i   (s_addr[g]),
            .s_wdata_i  (s_wdata[g]),
            .s_gnt_o    (s_gnt[g]),
            .s_rvalid_o (s_rvalid[g]),
            .s_rdata_o  (s_rdata[g]),
            .pim_en_o   (pim_en[g]),
            .pim_we_o   (pim_we[g]),
            .pim_addr_o (pim_addr[g]),
            .pim_wr_o   (pim_wr[g]),
            .pim_rd_i   (pim_rd[g]),
            .busy_o     (busy[g])
        );
    end

    int n_chk = 0;
    int n_bad = 0;

    // Pre-planned stimulus: read-data bus contents and reset pulses per cycle.
    logic [31:0] rd_hist  [NI][NCYC+1];
    bit          rst_plan [NI][NCYC+1];

    // Requesters (port 0 = core, port 1 = SPI).
    bit          rq_pend [NI][2];
    bit          rq_we   [NI][2];
    logic [31:0] rq_addr [NI][2];
    logic [31:0] rq_wd   [NI][2];

    // Model: one transaction in flight, described by its timestamps.
    bit          inflight [NI];
    int          t_iss    [NI];
    int          t_rsp    [NI];
    int          mport    [NI];
    bit          mwe      [NI];
    bit          ptr_spi  [NI];
    logic [31:0] addr_h   [NI];
    logic [31:0] wr_h     [NI];
    logic [31:0] rdat     [NI][2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
    endfunction

    task automatic chk(input string tag, input int k, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d cyc=%0d got=%h exp=%h", tag, lat_of(k), c, got, exp);
        end
    endtask

    task automatic drive(input int c);
        for (int k = 0; k < NI; k++) begin
            rst[k]     = rst_plan[k][c];
            c_req[k]   = rq_pend[k][0];
            c_we[k]    = rq_we[k][0];
            c_addr[k]  = rq_addr[k][0];
            c_wdata[k] = rq_wd[k][0];
            s_req[k]   = rq_pend[k][1];
            s_we[k]    = rq_we[k][1];
            s_addr[k]  = rq_addr[k][1];
            s_wdata[k] = rq_wd[k][1];
            pim_rd[k]  = rd_hist[k][c];
        end
    endtask

    task automatic new_requests(input int k, input int c);
        for (int p = 0; p < 2; p++) begin
            if (!rq_pend[k][p]) begin
                if (c < PH_A) begin
                    rq_pend[k][p] = 1'b1;
                    rq_we[k][p]   = 1'b1;
                end else if ($urandom_range(0, 99) < 40) begin
                    rq_pend[k][p] = 1'b1;
                    rq_we[k][p]   = 1'($urandom_range(0, 1));
                end
                if (rq_pend[k][p]) begin
                    rq_addr[k][p] = $urandom;
                    rq_wd[k][p]   = $urandom;
                end
            end
        end
    endtask

    task automatic step(input int k, input int c);
        int L;
        int w;
        bit r;
        bit e_busy, e_en, e_we, e_rv0, e_rv1;
        L = lat_of(k);
        r = rst_plan[k][c];
        w = -1;

        // Read data lands in the port register on the edge that starts RESP.
        if (inflight[k] && c == t_rsp[k] && !mwe[k])
            rdat[k][mport[k]] = rd_hist[k][c-1];

        if (!r && !inflight[k]) begin
            if (rq_pend[k][0] && rq_pend[k][1]) w = ptr_spi[k] ? 1 : 0;
            else if (rq_pend[k][0])             w = 0;
            else if (rq_pend[k][1])             w = 1;
        end
        e_busy = !r && inflight[k] && c >= t_iss[k];
        e_en   = !r && inflight[k] && c == t_iss[k];
        e_we   = e_en && mwe[k];
        e_rv0  = !r && inflight[k] && c == t_rsp[k] && mport[k] == 0;
        e_rv1  = !r && inflight[k] && c == t_rsp[k] && mport[k] == 1;

        chk("c_gnt",    k, c, 32'(c_gnt[k]),    32'(w == 0));
        chk("s_gnt",    k, c, 32'(s_gnt[k]),    32'(w == 1));
        chk("busy",     k, c, 32'(busy[k]),     32'(e_busy));
        chk("pim_en",   k, c, 32'(pim_en[k]),   32'(e_en));
        chk("pim_we",   k, c, 32'(pim_we[k]),   32'(e_we));
        chk("pim_addr", k, c, pim_addr[k],      addr_h[k]);
        chk("pim_wr",   k, c, pim_wr[k],        wr_h[k]);
        chk("c_rvalid", k, c, 32'(c_rvalid[k]), 32'(e_rv0));
        chk("s_rvalid", k, c, 32'(s_rvalid[k]), 32'(e_rv1));
        chk("c_rdata",  k, c, c_rdata[k],       rdat[k][0]);
        chk("s_rdata",  k, c, s_rdata[k],       rdat[k][1]);

        if (r) begin
            inflight[k] = 1'b0;
            ptr_spi[k]  = 1'b0;
            addr_h[k]   = '0;
            wr_h[k]     = '0;
            rdat[k][0]  = '0;
            rdat[k][1]  = '0;
        end else begin
            if (inflight[k] && c == t_rsp[k]) inflight[k] = 1'b0;
            if (w >= 0) begin
                inflight[k] = 1'b1;
                mport[k]    = w;
                mwe[k]      = rq_we[k][w];
                t_iss[k]    = c + 1;
                t_rsp[k]    = rq_we[k][w] ? c + 2 : c + L + 2;
                ptr_spi[k]  = (w == 0);
                addr_h[k]   = rq_addr[k][w];
                wr_h[k]     = rq_wd[k][w];
                rq_pend[k][w] = 1'b0;
            end
        end
        new_requests(k, c);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c <= NCYC; c++) begin
                rd_hist[k][c]  = $urandom;
                rst_plan[k][c] = (c < 3) || (c >= PH_A && $urandom_range(0, 99) < 2);
            end
            for (int p = 0; p < 2; p++) begin
                rq_pend[k][p] = 1'b0;
                rq_we[k][p]   = 1'b0;
                rq_addr[k][p] = '0;
                rq_wd[k][p]   = '0;
            end
            inflight[k] = 1'b0;
            t_iss[k]    = 0;
            t_rsp[k]    = 0;
            mport[k]    = 0;
            mwe[k]      = 1'b0;
            ptr_spi[k]  = 1'b0;
            addr_h[k]   = '0;
            wr_h[k]     = '0;
            rdat[k][0]  = '0;
            rdat[k][1]  = '0;
        end
        drive(0);
        @(posedge clk);
        #1;
        drive(0);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) step(k, c);
            @(posedge clk);
            #1;
            drive(c + 1);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
